// File: rtl/hilo_ctrl.sv
// HI/LO register unit behind the combinational mult/div unit: stalls the pipeline
// for a fixed per-op latency, then captures the unit's outputs; also serves MTHI/MTLO.
module hilo_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_mult,
  input  logic        op_div,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic        div_zero,
  input  logic [31:0] wdata,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           dz_reg, dz_next;
  logic [31:0]    hi_reg, hi_next;
  logic [31:0]    lo_reg, lo_next;
  logic           stall_next, done_next;
  logic           live;

  // An instruction only acts if it is valid and not being cancelled this cycle.
  assign live = op_valid & ~flush;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dz_next    = dz_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    stall_next = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (live && op_mult) begin
          state_next = BUSY;
          cnt_next   = MULT_LOAD;
          dz_next    = 1'b0;
          stall_next = 1'b1;
        end else if (live && op_div) begin
          state_next = BUSY;
          cnt_next   = DIV_LOAD;
          dz_next    = div_zero;
          stall_next = 1'b1;
        end else if (live && op_mthi) begin
          hi_next = wdata;
        end else if (live && op_mtlo) begin
          lo_next = wdata;
        end
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg != '0) begin
          stall_next = 1'b1;
          cnt_next   = cnt_reg - CW'(1);
        end else begin
          // Final cycle: pipeline released, unit outputs still held for capture.
          done_next  = 1'b1;
          state_next = IDLE;
          if (!dz_reg) begin
            hi_next = mul_hi;
            lo_next = mul_lo;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dz_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dz_reg    <= dz_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign stall = stall_next & ~reset;
  assign done  = done_next & ~reset;
  assign busy  = (state_reg == BUSY) & ~reset;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule
